// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Single-port data-memory arbiter and access sequencer. Shares one
//            word-addressed data memory between the pipeline memory stage
//            (requester P) and an external loader/debug port (requester X).
//            Every access runs IDLE -> ISSUE -> [WAIT] -> RESP. The pipeline
//            is stalled while its access is outstanding, and X is guaranteed
//            a grant after STARVE_MAX consecutive P grants made while it waits.
//
// Ports    : clk, rst            clock, synchronous active-high reset
//            p_req_i/p_we_i      P request / write select (held until done)
//            p_addr_i/p_wdata_i  P byte address (bits [1:0] ignored) / data
//            p_rdata_o           last data read by P
//            p_done_o            one-cycle P completion pulse
//            p_stall_o           p_req_i & ~p_done_o (combinational)
//            x_*                 same set for requester X, x_ack_o = pulse
//            m_en_o/m_we_o       memory strobe / write enable (ISSUE only)
//            m_addr_o/m_wdata_o  latched word address / write data
//            m_rdata_i           memory read data, MEM_LAT cycles after m_en
//            busy_o              sequencer not idle
//            owner_o             0 = P, 1 = X, owner of current/last access
//            oor_err_o           sticky out-of-range access flag
//
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int DEPTH      = 128,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    // Requester P (pipeline memory stage)
    input  logic              p_req_i,
    input  logic              p_we_i,
    input  logic [ADDR_W-1:0] p_addr_i,
    input  logic [DATA_W-1:0] p_wdata_i,
    output logic [DATA_W-1:0] p_rdata_o,
    output logic              p_done_o,
    output logic              p_stall_o,

    // Requester X (loader / debug)
    input  logic              x_req_i,
    input  logic              x_we_i,
    input  logic [ADDR_W-1:0] x_addr_i,
    input  logic [DATA_W-1:0] x_wdata_i,
    output logic [DATA_W-1:0] x_rdata_o,
    output logic              x_ack_o,

    // Data memory
    output logic              m_en_o,
    output logic              m_we_o,
    output logic [ADDR_W-3:0] m_addr_o,
    output logic [DATA_W-1:0] m_wdata_o,
    input  logic [DATA_W-1:0] m_rdata_i,

    // Status
    output logic              busy_o,
    output logic              owner_o,
    output logic              oor_err_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_WORD_W   = ADDR_W - 2;
    localparam int c_STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    // One extra bit so that DEPTH == 2**c_WORD_W still compares correctly.
    localparam logic [c_WORD_W:0]     c_DEPTH_EXT  = (c_WORD_W + 1)'(DEPTH);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_MAX);

    // WAIT lasts MEM_LAT-1 cycles; the counter runs from MEM_LAT-2 down to 0.
    localparam logic [1:0] c_WAIT_INIT = 2'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                state_q,   state_d;
    logic                  owner_q,   owner_d;
    logic                  we_q,      we_d;
    logic [c_WORD_W-1:0]   addr_q,    addr_d;
    logic [DATA_W-1:0]     wdata_q,   wdata_d;
    logic [1:0]            wait_q,    wait_d;
    logic [c_STARVE_W-1:0] starve_q,  starve_d;
    logic                  oor_q,     oor_d;
    logic [DATA_W-1:0]     p_rdata_q, p_rdata_d;
    logic [DATA_W-1:0]     x_rdata_q, x_rdata_d;
    logic                  p_done_q,  p_done_d;
    logic                  x_ack_q,   x_ack_d;

    logic                  w_p_elig;
    logic                  w_x_elig;
    logic                  w_x_wins;
    logic                  w_oor;
    logic [DATA_W-1:0]     w_rd_val;

    // Byte-lane bits of the requester addresses are intentionally dropped.
    logic                  w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = ^{p_addr_i[1:0], x_addr_i[1:0]};

    // ------------------------------------------------------------------------
    // Arbitration helpers
    // ------------------------------------------------------------------------
    // A requester in its completion cycle is still holding (or re-raising)
    // req; it must not be re-granted on the strength of the finished access.
    assign w_p_elig = p_req_i & ~p_done_q;
    assign w_x_elig = x_req_i & ~x_ack_q;

    // P has priority unless X has waited through STARVE_MAX P grants.
    assign w_x_wins = w_x_elig & ((starve_q == c_STARVE_MAX) | ~w_p_elig);

    assign w_oor    = ({1'b0, addr_q} >= c_DEPTH_EXT);

    // Out-of-range reads return zero instead of whatever the bus carries.
    assign w_rd_val = w_oor ? '0 : m_rdata_i;

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wait_d    = wait_q;
        starve_d  = starve_q;
        oor_d     = oor_q;
        p_rdata_d = p_rdata_q;
        x_rdata_d = x_rdata_q;
        p_done_d  = 1'b0;
        x_ack_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // No one is waiting on the X side: the fairness window resets.
                if (!x_req_i) begin
                    starve_d = '0;
                end

                if (w_x_wins) begin
                    state_d  = S_ISSUE;
                    owner_d  = 1'b1;
                    we_d     = x_we_i;
                    addr_d   = x_addr_i[ADDR_W-1:2];
                    wdata_d  = x_wdata_i;
                    starve_d = '0;
                end else if (w_p_elig) begin
                    state_d  = S_ISSUE;
                    owner_d  = 1'b0;
                    we_d     = p_we_i;
                    addr_d   = p_addr_i[ADDR_W-1:2];
                    wdata_d  = p_wdata_i;
                    // Only grants that actually make X wait count against it.
                    if (x_req_i && (starve_q != c_STARVE_MAX)) begin
                        starve_d = starve_q + c_STARVE_W'(1);
                    end
                end
            end

            S_ISSUE: begin
                if (w_oor) begin
                    oor_d = 1'b1;
                end
                if (MEM_LAT > 1) begin
                    state_d = S_WAIT;
                    wait_d  = c_WAIT_INIT;
                end else begin
                    state_d = S_RESP;
                end
            end

            S_WAIT: begin
                if (wait_q == 2'd0) begin
                    state_d = S_RESP;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
                // Writes leave the requester's read-data register untouched.
                if (!we_q) begin
                    if (owner_q) begin
                        x_rdata_d = w_rd_val;
                    end else begin
                        p_rdata_d = w_rd_val;
                    end
                end
                if (owner_q) begin
                    x_ack_d = 1'b1;
                end else begin
                    p_done_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wait_q    <= 2'd0;
            starve_q  <= '0;
            oor_q     <= 1'b0;
            p_rdata_q <= '0;
            x_rdata_q <= '0;
            p_done_q  <= 1'b0;
            x_ack_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wait_q    <= wait_d;
            starve_q  <= starve_d;
            oor_q     <= oor_d;
            p_rdata_q <= p_rdata_d;
            x_rdata_q <= x_rdata_d;
            p_done_q  <= p_done_d;
            x_ack_q   <= x_ack_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // The strobe is suppressed for out-of-range words so the array is never
    // touched; the access still runs its full sequence.
    assign m_en_o    = (state_q == S_ISSUE) & ~w_oor;
    assign m_we_o    = m_en_o & we_q;
    assign m_addr_o  = addr_q;
    assign m_wdata_o = wdata_q;

    assign p_rdata_o = p_rdata_q;
    assign p_done_o  = p_done_q;
    assign p_stall_o = p_req_i & ~p_done_q;
    assign x_rdata_o = x_rdata_q;
    assign x_ack_o   = x_ack_q;

    assign busy_o    = (state_q != S_IDLE);
    assign owner_o   = owner_q;
    assign oor_err_o = oor_q;

endmodule
`default_nettype wire
